// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial bus arbiter/transmitter:
//   state_t     - transmitter FSM states
//   MOD_PRIO    - channel mode code that wins arbitration over all others
//   CRC_POLY    - CRC-4 polynomial x^4+x+1 (x^4 term implicit)
//   frame_len() - total frame length in bits for a given address/data width
//   crc4_step() - one serial CRC-4 update step
// ----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        HDR,
        DATA,
        CRC
    } state_t;

    localparam logic [1:0] MOD_PRIO = 2'b11;
    localparam logic [3:0] CRC_POLY = 4'b0011;

    // start + src + dst + mod + data + crc
    function automatic int frame_len(input int addr_w, input int data_w);
        return 7 + 2 * addr_w + data_w;
    endfunction

    // Shift left, fold the feedback bit back in through the polynomial taps.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Two-class round-robin selector. Requesters flagged as priority beat all
// normal requesters; within the winning class the search starts at
// i_last+1 and wraps N_CH-1 -> 0. Purely combinational.
// Ports:
//   i_req    [N_CH]   - request vector
//   i_prio   [N_CH]   - per-channel priority flag
//   i_last   [ADDR_W] - index of previous winner
//   o_valid           - at least one request present
//   o_winner [ADDR_W] - selected channel (0 when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_CH   = 16,
    localparam int ADDR_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]   i_req,
    input  logic [N_CH-1:0]   i_prio,
    input  logic [ADDR_W-1:0] i_last,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_winner
);

    logic [N_CH-1:0] w_hi;
    logic [N_CH-1:0] w_cand;
    logic [ADDR_W:0] w_idx;   // one extra bit so last+k never overflows
    logic            w_found;

    always_comb begin
        w_hi     = i_req & i_prio;
        w_cand   = (|w_hi) ? w_hi : i_req;
        o_valid  = |i_req;
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = {1'b0, i_last} + (ADDR_W+1)'(k);
            if (w_idx >= (ADDR_W+1)'(N_CH))
                w_idx = w_idx - (ADDR_W+1)'(N_CH);
            if (!w_found && w_cand[w_idx[ADDR_W-1:0]]) begin
                w_found  = 1'b1;
                o_winner = w_idx[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_tx.sv
// ----------------------------------------------------------------------------
// bus_arbiter_tx
// Arbitrates N_CH transmit channels onto one serial line and sends a frame
// MSB first: start(1) src(ADDR_W) dst(ADDR_W) mod(2) data(DATA_W) crc(4).
// The CRC-4 covers src through data and is computed as the bits go out.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   req      [N_CH]   - level request, held until ack
//   tx_data  [N_CH*DATA_W], tx_dst [N_CH*ADDR_W], tx_mod [N_CH*2]
//                     - per-channel frame fields, channel i at slice i
//   ack      [N_CH]   - one-cycle grant pulse, coincides with the start bit
//   grant_id [ADDR_W] - current / most recent bus owner
//   busy              - start bit through last CRC bit
//   frame_done        - pulses with the last CRC bit
//   bus_out           - registered serial line, idle low
// ----------------------------------------------------------------------------
module bus_arbiter_tx
    import bus_pkg::*;
#(
    parameter  int N_CH   = 16,
    parameter  int DATA_W = 64,
    localparam int ADDR_W = $clog2(N_CH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*DATA_W-1:0]   tx_data,
    input  logic [N_CH*ADDR_W-1:0]   tx_dst,
    input  logic [N_CH*2-1:0]        tx_mod,
    output logic [N_CH-1:0]          ack,
    output logic [ADDR_W-1:0]        grant_id,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     bus_out
);

    localparam int HDR_LEN = 2 * ADDR_W + 2;
    localparam int SH_W    = HDR_LEN + DATA_W;
    localparam int CNT_W   = $clog2(DATA_W + 1);

    state_t              r_state;
    logic [SH_W-1:0]     r_shift;   // src/dst/mod/data latched at grant
    logic [CNT_W-1:0]    r_cnt;     // bits already sent in current state
    logic [3:0]          r_crc;
    logic [ADDR_W-1:0]   r_last;
    logic [ADDR_W-1:0]   r_grant;
    logic [N_CH-1:0]     r_ack;
    logic                r_busy;
    logic                r_done;
    logic                r_bus;

    logic [N_CH-1:0]     w_prio;
    logic                w_valid;
    logic [ADDR_W-1:0]   w_win;
    logic [ADDR_W-1:0]   w_dst;
    logic [1:0]          w_mod;
    logic [DATA_W-1:0]   w_data;
    logic                w_bit;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_req    (req),
        .i_prio   (w_prio),
        .i_last   (r_last),
        .o_valid  (w_valid),
        .o_winner (w_win)
    );

    // Priority flags and winner field mux.
    always_comb begin
        w_prio = '0;
        w_dst  = '0;
        w_mod  = '0;
        w_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_prio[i] = (tx_mod[2*i +: 2] == MOD_PRIO);
            if (w_win == ADDR_W'(i)) begin
                w_dst  = tx_dst[i*ADDR_W +: ADDR_W];
                w_mod  = tx_mod[2*i +: 2];
                w_data = tx_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_bit = r_shift[SH_W-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_crc   <= '0;
            r_last  <= ADDR_W'(N_CH - 1);
            r_grant <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bus   <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= START;
                        r_ack   <= N_CH'(1) << w_win;
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_shift <= {w_win, w_dst, w_mod, w_data};
                        r_crc   <= '0;
                        r_cnt   <= '0;
                        r_bus   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    r_bus   <= w_bit;
                    r_shift <= {r_shift[SH_W-2:0], 1'b0};
                    r_crc   <= crc4_step(r_crc, w_bit);
                    r_cnt   <= CNT_W'(1);
                    r_state <= HDR;
                end
                HDR: begin
                    // The edge that closes the header already emits data bit 1.
                    r_bus   <= w_bit;
                    r_shift <= {r_shift[SH_W-2:0], 1'b0};
                    r_crc   <= crc4_step(r_crc, w_bit);
                    if (r_cnt == CNT_W'(HDR_LEN)) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_W'(DATA_W)) begin
                        // CRC register is complete here; send it MSB first.
                        r_bus   <= r_crc[3];
                        r_crc   <= {r_crc[2:0], 1'b0};
                        r_cnt   <= CNT_W'(1);
                        r_state <= CRC;
                    end else begin
                        r_bus   <= w_bit;
                        r_shift <= {r_shift[SH_W-2:0], 1'b0};
                        r_crc   <= crc4_step(r_crc, w_bit);
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                CRC: begin
                    if (r_cnt == CNT_W'(4)) begin
                        r_state <= IDLE;
                        r_bus   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_bus  <= r_crc[3];
                        r_crc  <= {r_crc[2:0], 1'b0};
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_done <= (r_cnt == CNT_W'(3));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack        = r_ack;
    assign grant_id   = r_grant;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign bus_out    = r_bus;

endmodule

// File: tb/tb_bus_arbiter_tx.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_tx
// Directed bench: a small instance (N_CH=4, DATA_W=8) checked against a
// hand-written frame, and a default instance (16 x 64) checked against a
// frame builder for arbitration order, wrap-around, priority, payload
// latching and mid-frame reset.
// ----------------------------------------------------------------------------
module tb_bus_arbiter_tx;

    logic clock;
    logic reset;

    // small instance
    logic [3:0]   s_req;
    logic [31:0]  s_data;
    logic [7:0]   s_dst;
    logic [7:0]   s_mod;
    logic [3:0]   s_ack;
    logic [1:0]   s_gid;
    logic         s_busy, s_done, s_bus;

    // default instance
    logic [15:0]   d_req;
    logic [1023:0] d_data;
    logic [63:0]   d_dst;
    logic [31:0]   d_mod;
    logic [15:0]   d_ack;
    logic [3:0]    d_gid;
    logic          d_busy, d_done, d_bus;

    int checks = 0;
    int errors = 0;

    bus_arbiter_tx #(.N_CH(4), .DATA_W(8)) dut_s (
        .clock(clock), .reset(reset), .req(s_req), .tx_data(s_data),
        .tx_dst(s_dst), .tx_mod(s_mod), .ack(s_ack), .grant_id(s_gid),
        .busy(s_busy), .frame_done(s_done), .bus_out(s_bus)
    );

    bus_arbiter_tx dut_d (
        .clock(clock), .reset(reset), .req(d_req), .tx_data(d_data),
        .tx_dst(d_dst), .tx_mod(d_mod), .ack(d_ack), .grant_id(d_gid),
        .busy(d_busy), .frame_done(d_done), .bus_out(d_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame for the default instance (ADDR_W=4, DATA_W=64).
    function automatic logic [78:0] expf(input logic [3:0] s, input logic [3:0] d,
                                         input logic [1:0] m, input logic [63:0] x);
        logic [73:0] p;
        logic [3:0]  c;
        logic        fb;
        p = {s, d, m, x};
        c = 4'b0000;
        for (int i = 73; i >= 0; i--) begin
            fb = c[3] ^ p[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return {1'b1, p, c};
    endfunction

    function automatic logic [78:0] expch(input int ch);
        return expf(4'(ch), d_dst[ch*4 +: 4], d_mod[ch*2 +: 2], d_data[ch*64 +: 64]);
    endfunction

    // Wait for an ack on the default instance, then capture the whole frame
    // and the following idle gap cycle.
    task automatic cap_d(input bit do_chg, input logic [63:0] chg,
                         output logic [78:0] f, output int win, output int wt);
        bit   early;
        bit   nobusy;
        logic lastd;
        f = '0; win = -1; wt = 0; early = 0; nobusy = 0; lastd = 1'b0;
        do begin
            @(negedge clock);
            wt++;
        end while (d_ack == '0 && wt < 40);
        chk("ack_seen", 128'(d_ack != '0), 1);
        if (d_ack == '0) return;
        for (int i = 0; i < 16; i++) if (d_ack[i]) win = i;
        chk("ack_onehot", 128'($countones(d_ack)), 1);
        chk("gid_at_ack", d_gid, win);
        d_req[win] = 1'b0;
        f[78] = d_bus;
        if (d_done) early = 1;
        if (!d_busy) nobusy = 1;
        for (int k = 77; k >= 0; k--) begin
            @(negedge clock);
            f[k] = d_bus;
            if (!d_busy) nobusy = 1;
            if (k == 0) lastd = d_done;
            else if (d_done) early = 1;
            if (do_chg && k == 77) d_data[win*64 +: 64] = chg;
        end
        chk("done_last", lastd, 1);
        chk("done_early", early, 0);
        chk("busy_frame", nobusy, 0);
        @(negedge clock);
        chk("gap_bus", d_bus, 0);
        chk("gap_busy", d_busy, 0);
        chk("gap_done", d_done, 0);
    endtask

    initial begin
        logic [18:0] sf;
        logic [18:0] s_exp;
        logic [78:0] f;
        logic [78:0] e;
        logic [63:0] orig;
        int          win, wt, nd, na;
        bit          early;
        logic        lastd;

        reset = 1'b1;
        s_req = '0; s_data = '0; s_dst = '0; s_mod = '0;
        d_req = '0; d_mod = '0;
        for (int i = 0; i < 16; i++) begin
            d_data[i*64 +: 64] = {16{4'(i)}} ^ 64'h0123_4567_89AB_CDEF;
            d_dst[i*4 +: 4]    = 4'(15 - i);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_s_bus", s_bus, 0);
        chk("rst_s_busy", s_busy, 0);
        chk("rst_s_ack", s_ack, 0);
        chk("rst_s_done", s_done, 0);
        chk("rst_s_gid", s_gid, 0);
        chk("rst_d_gid", d_gid, 0);
        chk("rst_d_bus", d_bus, 0);
        reset = 1'b0;
        @(negedge clock);

        // Small instance: hand-computed 19-bit frame.
        s_data[7:0] = 8'h01;
        s_dst[1:0]  = 2'b01;
        s_mod[1:0]  = 2'b01;
        s_req       = 4'b0001;
        wt = 0;
        do begin
            @(negedge clock);
            wt++;
        end while (s_ack == '0 && wt < 20);
        chk("s_ack_lat", wt, 1);
        chk("s_ack", s_ack, 4'b0001);
        chk("s_busy", s_busy, 1);
        s_req = '0;
        sf = '0; early = 0; lastd = 1'b0;
        sf[18] = s_bus;
        if (s_done) early = 1;
        for (int k = 17; k >= 0; k--) begin
            @(negedge clock);
            sf[k] = s_bus;
            if (k == 0) lastd = s_done;
            else if (s_done) early = 1;
        end
        s_exp = 19'b1_00_01_01_00000001_0101;
        chk("s_frame", sf, s_exp);
        chk("s_done_last", lastd, 1);
        chk("s_done_early", early, 0);
        @(negedge clock);
        chk("s_gap_bus", s_bus, 0);
        chk("s_gap_busy", s_busy, 0);

        // ch1 and ch3 after reset: ch1 first, then ch3 after one idle cycle.
        d_req[1] = 1'b1;
        d_req[3] = 1'b1;
        cap_d(0, '0, f, win, wt);
        chk("rr_first", win, 1);
        chk("rr_first_lat", wt, 1);
        e = expch(1);
        chk("rr_first_frame", f, e);
        cap_d(0, '0, f, win, wt);
        chk("rr_second", win, 3);
        chk("rr_second_gap", wt, 1);
        e = expch(3);
        chk("rr_second_frame", f, e);
        chk("gid_hold", d_gid, 3);

        // ch15, then ch0 and ch15 together: wrap-around picks ch0.
        d_req[15] = 1'b1;
        cap_d(0, '0, f, win, wt);
        chk("wrap_15", win, 15);
        d_req[0]  = 1'b1;
        d_req[15] = 1'b1;
        cap_d(0, '0, f, win, wt);
        chk("wrap_0", win, 0);
        e = expch(0);
        chk("wrap_0_frame", f, e);
        cap_d(0, '0, f, win, wt);
        chk("wrap_15b", win, 15);

        // ch2 (mode 01, normal) vs ch9 (mode 11): ch9 first despite RR order.
        d_mod[2*2 +: 2] = 2'b01;
        d_mod[9*2 +: 2] = 2'b11;
        d_req[2] = 1'b1;
        d_req[9] = 1'b1;
        cap_d(0, '0, f, win, wt);
        chk("prio_first", win, 9);
        e = expch(9);
        chk("prio_frame", f, e);
        cap_d(0, '0, f, win, wt);
        chk("prio_second", win, 2);
        e = expch(2);
        chk("prio_second_frame", f, e);

        // Payload changed after ack must not reach the bus.
        e    = expch(7);
        orig = d_data[7*64 +: 64];
        d_req[7] = 1'b1;
        cap_d(1, ~orig, f, win, wt);
        chk("latch_win", win, 7);
        chk("latch_frame", f, e);
        d_data[7*64 +: 64] = orig;

        // Reset at bit 40 of a ch5 frame.
        e = expch(5);
        d_req[5] = 1'b1;
        wt = 0;
        do begin
            @(negedge clock);
            wt++;
        end while (d_ack == '0 && wt < 40);
        chk("rst_ack", d_ack, 16'h0020);
        d_req[5] = 1'b0;
        f = '0;
        f[78] = d_bus;
        for (int k = 77; k >= 39; k--) begin
            @(negedge clock);
            f[k] = d_bus;
        end
        chk("rst_partial", f[78:39], e[78:39]);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_bus", d_bus, 0);
        chk("rst_mid_busy", d_busy, 0);
        chk("rst_mid_done", d_done, 0);
        chk("rst_mid_gid", d_gid, 0);
        reset = 1'b0;
        nd = 0; na = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (d_done) nd++;
            if (d_ack != '0) na++;
        end
        chk("rst_no_done", nd, 0);
        chk("rst_no_ack", na, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_tx.md
BUS_ARBITER_TX -- requirements
Module: bus_arbiter_tx

Interface
REQ-001 SHALL have parameter N_CH, default 16: number of transmitting channels, range 2..16.
REQ-002 SHALL have parameter DATA_W, default 64: payload width per channel, range 8..64.
REQ-003 SHALL have derived constant ADDR_W = clog2(N_CH): address width, 4 at default.
REQ-004 SHALL have port clock, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, N_CH: per-channel transmit request, level-held until ack.
REQ-007 SHALL have port tx_data, input, N_CH*DATA_W: payloads; channel i at slice i.
REQ-008 SHALL have port tx_dst, input, N_CH*ADDR_W: destination address per channel.
REQ-009 SHALL have port tx_mod, input, N_CH*2: mode per channel; 2'b11 = priority, other codes normal.
REQ-010 SHALL have port ack, output, N_CH: one-cycle pulse to the granted channel.
REQ-011 SHALL have port grant_id, output, ADDR_W: index of the channel currently owning the bus.
REQ-012 SHALL have port busy, output, 1: high while a frame is on the bus.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse marking the last frame bit.
REQ-014 SHALL have port bus_out, output, 1: registered serial bus line, idle low.

Function
REQ-015 Frame layout, MSB first, SHALL be: start bit 1, src (grant index, ADDR_W), dst (ADDR_W), mod (2), data (DATA_W), CRC (4). Length = 7+2*ADDR_W+DATA_W; 79 bits at defaults.
REQ-016 CRC SHALL be serial CRC-4, polynomial x^4+x+1, init 0000, covering src through data. Per bit: fb = c3^b; next = {c2, c1, c0^fb, fb}.
REQ-017 FSM states SHALL be IDLE, START, HDR, DATA, CRC: IDLE->START on any req; START->HDR; HDR->DATA after 2*ADDR_W+2 bits; DATA->CRC after DATA_W bits; CRC->IDLE after 4 bits.
REQ-018 In IDLE with any req high, the block SHALL select a winner and latch its src, dst, mod and data at that edge; later input changes SHALL NOT affect the frame.
REQ-019 Arbitration: requesters with mod==2'b11 SHALL beat all others; within the winning class, round-robin starting at last_grant+1, wrapping N_CH-1->0.
REQ-020 ack[winner] and the start bit SHALL appear in the cycle after the arbitration edge; busy SHALL be high from that cycle through the last CRC bit.
REQ-021 frame_done SHALL pulse in the cycle the last CRC bit is on bus_out; the following cycle SHALL be IDLE with bus_out=0, giving a 1-cycle minimum inter-frame gap.
REQ-022 A req still high after its ack SHALL be treated as a new request; a req dropped before grant SHALL be ignored without error.
REQ-023 grant_id SHALL hold the last winner when idle.

Reset
REQ-024 On reset: state IDLE; bus_out=0, busy=0, ack=0, frame_done=0, grant_id=0, CRC=0000, last_grant=N_CH-1.
REQ-025 Reset mid-frame SHALL abort the frame: bus_out=0 from the next cycle, no frame_done, no ack replay.

Structure
REQ-026 A shared package bus_pkg SHALL hold the state enumeration, MOD_PRIO=2'b11, CRC_POLY=4'b0011 and the frame-length function.
REQ-027 Round-robin/priority selection SHALL be one sub-module, rr_arbiter, parametrised on N_CH.

Verification
REQ-028 N_CH=4, DATA_W=8; ch0 req, dst=01, mod=01, data=8'h01 -> ack[0] and start bit one cycle later. Bus bits: 1 00 01 01 00000001 0101, 19 bits. frame_done on bit 19.
REQ-029 Defaults; ch1 and ch3 req together, both normal mode, after reset -> ch1 sent first, 1 idle gap, then ch3.
REQ-030 Defaults; ch2 normal and ch9 mod=11 req together -> ch9 granted first.
REQ-031 Defaults; ch15 granted, then ch0 and ch15 re-request -> ch0 next (wrap-around).
REQ-032 Reset asserted at bit 40 of a 79-bit frame -> bus_out=0 and busy=0 the next cycle, no frame_done.
REQ-033 Defaults; tx_data changed one cycle after ack -> transmitted payload equals the value latched at the grant edge.
